// File: rtl/pifo_calendar_cpu_master_if.sv
// Purpose : bundles the host request/response channel and the calendar CPU
//           channel of pifo_calendar_cpu_master into one port.
// Latency : none (wires only).
// Backpressure: host_req_ready / host_rsp_ready carry the host-side handshake.
// Modports: master = the access master itself; slave = its peers
//           (register bridge plus calendar).
interface pifo_calendar_cpu_master_if #(
  parameter int PIFO_CALENDAR_INDEX_WIDTH = 10,
  parameter int PIFO_ROOT_WIDTH           = 32
);
  // host request channel
  logic                                 host_req_valid;
  logic                                 host_req_ready;
  logic                                 host_req_write;
  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] host_req_addr;
  logic [PIFO_ROOT_WIDTH-1:0]           host_req_wdata;
  // host response channel
  logic                                 host_rsp_valid;
  logic                                 host_rsp_ready;
  logic [PIFO_ROOT_WIDTH-1:0]           host_rsp_rdata;
  logic                                 host_rsp_err;
  // calendar CPU channel
  logic                                 cpu_rd_valid;
  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_rd_addr;
  logic                                 cpu_rd_result_valid;
  logic [PIFO_ROOT_WIDTH-1:0]           cpu_rd_result;
  logic                                 cpu_wr_valid;
  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_wr_addr;
  logic [PIFO_ROOT_WIDTH-1:0]           cpu_wr_data;
  logic                                 cpu_wr_result_valid;

  modport master (
    input  host_req_valid, host_req_write, host_req_addr, host_req_wdata,
    output host_req_ready,
    output host_rsp_valid, host_rsp_rdata, host_rsp_err,
    input  host_rsp_ready,
    output cpu_rd_valid, cpu_rd_addr,
    input  cpu_rd_result_valid, cpu_rd_result,
    output cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
    input  cpu_wr_result_valid
  );

  modport slave (
    output host_req_valid, host_req_write, host_req_addr, host_req_wdata,
    input  host_req_ready,
    input  host_rsp_valid, host_rsp_rdata, host_rsp_err,
    output host_rsp_ready,
    input  cpu_rd_valid, cpu_rd_addr,
    output cpu_rd_result_valid, cpu_rd_result,
    input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
    output cpu_wr_result_valid
  );
endinterface

// File: rtl/pifo_calendar_cpu_master.sv
// Purpose : serialises host register reads/writes into single-cycle CPU pulses
//           toward the PIFO calendar, waits for the result strobe under a timeout.
// Latency : read rsp 3 cycles after request handshake (1-cycle calendar), OOR 1, timeout 2+TIMEOUT_CYCLES.
// Backpressure: one access outstanding; host_req_ready low outside IDLE; rsp held until host_rsp_ready.
// Ports   : clk, rstn (synchronous, active-low), bus (pifo_calendar_cpu_master_if.master).
//           With PIFO_CPU_MASTER_STATS_EN defined: stat_rd_count, stat_wr_count,
//           stat_timeout_count (16-bit saturating completion/timeout counters).
module pifo_calendar_cpu_master #(
  parameter int PIFO_CALENDAR_SIZE        = 1024,
  parameter int PIFO_CALENDAR_INDEX_WIDTH = 10,
  parameter int PIFO_ROOT_WIDTH           = 32,
  parameter int TIMEOUT_WIDTH             = 8,
  parameter int TIMEOUT_CYCLES            = 200
) (
  input  logic                         clk,
  input  logic                         rstn,
  pifo_calendar_cpu_master_if.master   bus
`ifdef PIFO_CPU_MASTER_STATS_EN
  ,
  output logic [15:0]                  stat_rd_count,
  output logic [15:0]                  stat_wr_count,
  output logic [15:0]                  stat_timeout_count
`endif
);

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]              SIZE_LIM  = 32'(PIFO_CALENDAR_SIZE);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP
  } state_t;

  state_t                               state;
  logic [TIMEOUT_WIDTH-1:0]             wait_cnt;
  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] req_addr;
  logic [PIFO_ROOT_WIDTH-1:0]           req_wdata;
  logic                                 req_ready;
  logic                                 rsp_valid;
  logic [PIFO_ROOT_WIDTH-1:0]           rsp_rdata;
  logic                                 rsp_err;
  logic                                 rd_pulse;
  logic                                 wr_pulse;

  // Address/data toward the calendar come straight from the latched request,
  // so they stay stable from ISSUE until the next request is accepted.
  assign bus.host_req_ready = req_ready;
  assign bus.host_rsp_valid = rsp_valid;
  assign bus.host_rsp_rdata = rsp_rdata;
  assign bus.host_rsp_err   = rsp_err;
  assign bus.cpu_rd_valid   = rd_pulse;
  assign bus.cpu_rd_addr    = req_addr;
  assign bus.cpu_wr_valid   = wr_pulse;
  assign bus.cpu_wr_addr    = req_addr;
  assign bus.cpu_wr_data    = req_wdata;

  // Transfer direction is carried by the state itself (RD_* vs WR_*), so only
  // address and write data need latching.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rd_pulse  <= 1'b0;
      wr_pulse  <= 1'b0;
`ifdef PIFO_CPU_MASTER_STATS_EN
      stat_rd_count      <= '0;
      stat_wr_count      <= '0;
      stat_timeout_count <= '0;
`endif
    end else begin
      rd_pulse <= 1'b0;
      wr_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.host_req_valid && req_ready) begin
            req_addr  <= bus.host_req_addr;
            req_wdata <= bus.host_req_wdata;
            req_ready <= 1'b0;
            if (32'(bus.host_req_addr) >= SIZE_LIM) begin
              // Out of range: answer immediately, calendar never sees it.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (bus.host_req_write) begin
              state    <= WR_ISSUE;
              wr_pulse <= 1'b1;
            end else begin
              state    <= RD_ISSUE;
              rd_pulse <= 1'b1;
            end
          end
        end
        RD_ISSUE: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end
        WR_ISSUE: begin
          wait_cnt <= '0;
          state    <= WR_WAIT;
        end
        RD_WAIT, WR_WAIT: begin
          // Only the strobe matching the direction is honoured; a strobe on the
          // final count beats the timeout.
          if ((state == RD_WAIT) ? bus.cpu_rd_result_valid : bus.cpu_wr_result_valid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= (state == RD_WAIT) ? bus.cpu_rd_result : '0;
`ifdef PIFO_CPU_MASTER_STATS_EN
            if (state == RD_WAIT) begin
              if (stat_rd_count != 16'hFFFF) stat_rd_count <= stat_rd_count + 16'd1;
            end else begin
              if (stat_wr_count != 16'hFFFF) stat_wr_count <= stat_wr_count + 16'd1;
            end
`endif
          end else if (wait_cnt == CNT_LAST) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
`ifdef PIFO_CPU_MASTER_STATS_EN
            if (stat_timeout_count != 16'hFFFF) stat_timeout_count <= stat_timeout_count + 16'd1;
`endif
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.host_rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pifo_calendar_cpu_master.sv
// Bench for pifo_calendar_cpu_master: directed scenarios plus a randomized
// run against a transaction-level reference model of request -> response.
module tb_pifo_calendar_cpu_master;
  localparam int SIZE = 1000;
  localparam int IW   = 10;
  localparam int RW   = 32;
  localparam int TC   = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_rd = 0, exp_wr = 0, exp_to = 0;

  pifo_calendar_cpu_master_if #(.PIFO_CALENDAR_INDEX_WIDTH(IW), .PIFO_ROOT_WIDTH(RW)) bus ();

`ifdef PIFO_CPU_MASTER_STATS_EN
  logic [15:0] stat_rd_count, stat_wr_count, stat_timeout_count;
`endif

  pifo_calendar_cpu_master #(
    .PIFO_CALENDAR_SIZE(SIZE), .PIFO_CALENDAR_INDEX_WIDTH(IW), .PIFO_ROOT_WIDTH(RW),
    .TIMEOUT_WIDTH(8), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
`ifdef PIFO_CPU_MASTER_STATS_EN
    , .stat_rd_count(stat_rd_count), .stat_wr_count(stat_wr_count),
    .stat_timeout_count(stat_timeout_count)
`endif
  );

  // observations returned by run_txn
  bit o_done, o_stable, o_busy, o_rdy;
  int o_nrd, o_nwr, o_pc, o_rc;
  logic [IW-1:0] o_pa;
  logic [RW-1:0] o_pd, o_rd;
  logic o_err;

  // Drives one host request and plays the calendar: the matching strobe comes
  // d cycles after the CPU pulse (d=0: never); 'wrong' pulses the other strobe
  // one cycle after the pulse. Cycle numbers count from the handshake edge T
  // (cycle T+1 is the one right after that edge).
  task automatic run_txn(input bit wr, input logic [IW-1:0] addr, input logic [RW-1:0] wdata,
                         input int d, input logic [RW-1:0] rdval, input int hold, input bit wrong,
                         output bit done, output int n_rd, output int n_wr, output int p_cyc,
                         output logic [IW-1:0] p_addr, output logic [RW-1:0] p_data,
                         output int r_cyc, output logic [RW-1:0] r_data, output logic r_err,
                         output bit stable, output bit busy_ok, output bit ready_after);
    int w;
    bit hs;
    done = 0; n_rd = 0; n_wr = 0; p_cyc = 0; p_addr = '0; p_data = '0;
    r_cyc = 0; r_data = '0; r_err = 1'b0; stable = 1; busy_ok = 1; ready_after = 0;
    @(posedge clk); #1;
    bus.host_req_valid = 1'b1;
    bus.host_req_write = wr;
    bus.host_req_addr  = addr;
    bus.host_req_wdata = wdata;
    bus.cpu_rd_result  = rdval;
    w = 0;
    while (!bus.host_req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.host_req_ready) begin
      bus.host_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.host_req_valid = 1'b0;
    hs = 0;
    for (int cyc = 1; cyc <= 300 && !hs; cyc++) begin
      @(negedge clk);
      if (bus.cpu_rd_valid) begin
        n_rd++;
        if (p_cyc == 0) begin p_cyc = cyc; p_addr = bus.cpu_rd_addr; end
      end
      if (bus.cpu_wr_valid) begin
        n_wr++;
        if (p_cyc == 0) begin p_cyc = cyc; p_addr = bus.cpu_wr_addr; p_data = bus.cpu_wr_data; end
      end
      if (bus.host_req_ready) busy_ok = 0;
      if (bus.host_rsp_valid) begin
        if (r_cyc == 0) begin
          r_cyc = cyc; r_data = bus.host_rsp_rdata; r_err = bus.host_rsp_err;
        end else if (bus.host_rsp_rdata !== r_data || bus.host_rsp_err !== r_err) begin
          stable = 0;
        end
      end
      bus.cpu_rd_result_valid = (p_cyc > 0) &&
        ((!wr && d > 0 && cyc == p_cyc + d) || (wr && wrong && cyc == p_cyc + 1));
      bus.cpu_wr_result_valid = (p_cyc > 0) &&
        ((wr && d > 0 && cyc == p_cyc + d) || (!wr && wrong && cyc == p_cyc + 1));
      bus.host_rsp_ready = (r_cyc > 0) && (cyc >= r_cyc + hold);
      if (bus.host_rsp_ready) hs = 1;
    end
    @(posedge clk); #1;
    bus.host_rsp_ready = 1'b0;
    bus.cpu_rd_result_valid = 1'b0;
    bus.cpu_wr_result_valid = 1'b0;
    if (hs) begin
      @(negedge clk);
      ready_after = bus.host_req_ready;
      done = 1;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.host_req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", bus.host_req_ready); end
    total++; if (bus.host_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.host_rsp_valid); end
    total++; if (bus.host_rsp_rdata !== '0 || bus.host_rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%h/%b exp=0/0", bus.host_rsp_rdata, bus.host_rsp_err); end
    total++; if (bus.cpu_rd_valid !== 1'b0 || bus.cpu_wr_valid !== 1'b0) begin bad++; $display("FAIL reset_cpu_valid got=%b%b exp=00", bus.cpu_rd_valid, bus.cpu_wr_valid); end
    total++; if (bus.cpu_rd_addr !== '0 || bus.cpu_wr_addr !== '0 || bus.cpu_wr_data !== '0) begin bad++; $display("FAIL reset_cpu_bus got=%h/%h/%h exp=0", bus.cpu_rd_addr, bus.cpu_wr_addr, bus.cpu_wr_data); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_read;
    run_txn(1'b0, 10'd5, '0, 1, 32'h8000_1234, 0, 1'b0,
            o_done, o_nrd, o_nwr, o_pc, o_pa, o_pd, o_rc, o_rd, o_err, o_stable, o_busy, o_rdy);
    exp_rd++;
    total++; if (!o_done) begin bad++; $display("FAIL read_done got=0 exp=1"); end
    total++; if (o_nrd != 1 || o_nwr != 0) begin bad++; $display("FAIL read_pulses got=rd%0d/wr%0d exp=rd1/wr0", o_nrd, o_nwr); end
    total++; if (o_pc != 1 || o_pa !== 10'd5) begin bad++; $display("FAIL read_issue got=cyc%0d addr%0d exp=cyc1 addr5", o_pc, o_pa); end
    total++; if (o_rc != 3) begin bad++; $display("FAIL read_latency got=%0d exp=3", o_rc); end
    total++; if (o_rd !== 32'h8000_1234 || o_err !== 1'b0) begin bad++; $display("FAIL read_rsp got=%h/%b exp=80001234/0", o_rd, o_err); end
    total++; if (!o_rdy) begin bad++; $display("FAIL read_next_ready got=0 exp=1"); end
  endtask

  task automatic test_write;
    // 999 is the top in-range index for this 1000-entry build
    run_txn(1'b1, 10'd999, 32'hDEAD_BEEF, 4, 32'h1111_2222, 0, 1'b0,
            o_done, o_nrd, o_nwr, o_pc, o_pa, o_pd, o_rc, o_rd, o_err, o_stable, o_busy, o_rdy);
    exp_wr++;
    total++; if (o_nwr != 1 || o_nrd != 0) begin bad++; $display("FAIL write_pulses got=wr%0d/rd%0d exp=wr1/rd0", o_nwr, o_nrd); end
    total++; if (o_pa !== 10'd999 || o_pd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL write_issue got=%0d/%h exp=999/deadbeef", o_pa, o_pd); end
    total++; if (o_rc != 6) begin bad++; $display("FAIL write_latency got=%0d exp=6", o_rc); end
    total++; if (o_rd !== '0 || o_err !== 1'b0 || !o_done) begin bad++; $display("FAIL write_rsp got=%h/%b done=%0d exp=0/0 done=1", o_rd, o_err, o_done); end
  endtask

  task automatic test_timeout;
    logic [RW-1:0] v;
    run_txn(1'b1, 10'd17, 32'h0BAD_F00D, 0, '0, 0, 1'b0,
            o_done, o_nrd, o_nwr, o_pc, o_pa, o_pd, o_rc, o_rd, o_err, o_stable, o_busy, o_rdy);
    exp_to++;
    total++; if (o_rc != TC + 2) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", o_rc, TC + 2); end
    total++; if (o_err !== 1'b1 || o_rd !== '0 || !o_done) begin bad++; $display("FAIL timeout_rsp got=%b/%h done=%0d exp=1/0 done=1", o_err, o_rd, o_done); end
    // returned in cycle T+13; late strobe goes in at T+15
    repeat (2) @(negedge clk);
    bus.cpu_wr_result_valid = 1'b1;
    bus.cpu_rd_result_valid = 1'b1;
    @(negedge clk);
    bus.cpu_wr_result_valid = 1'b0;
    bus.cpu_rd_result_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.host_rsp_valid !== 1'b0 || bus.host_req_ready !== 1'b1) begin bad++; $display("FAIL late_strobe_ignored got=valid%b ready%b exp=valid0 ready1", bus.host_rsp_valid, bus.host_req_ready); end
    end
    v = $urandom;
    run_txn(1'b0, 10'd7, '0, 2, v, 0, 1'b0,
            o_done, o_nrd, o_nwr, o_pc, o_pa, o_pd, o_rc, o_rd, o_err, o_stable, o_busy, o_rdy);
    exp_rd++;
    total++; if (o_rc != 4 || o_rd !== v || o_err !== 1'b0) begin bad++; $display("FAIL after_timeout_read got=cyc%0d %h/%b exp=cyc4 %h/0", o_rc, o_rd, o_err, v); end
  endtask

  task automatic test_out_of_range;
    run_txn(1'b0, 10'd1000, '0, 1, 32'h5555_5555, 0, 1'b0,
            o_done, o_nrd, o_nwr, o_pc, o_pa, o_pd, o_rc, o_rd, o_err, o_stable, o_busy, o_rdy);
    total++; if (o_nrd != 0 || o_nwr != 0) begin bad++; $display("FAIL oor_no_issue got=rd%0d/wr%0d exp=0/0", o_nrd, o_nwr); end
    total++; if (o_rc != 1 || o_err !== 1'b1 || o_rd !== '0) begin bad++; $display("FAIL oor_rsp got=cyc%0d %b/%h exp=cyc1 1/0", o_rc, o_err, o_rd); end
    run_txn(1'b1, 10'd1023, 32'hDEAD_BEEF, 1, '0, 0, 1'b0,
            o_done, o_nrd, o_nwr, o_pc, o_pa, o_pd, o_rc, o_rd, o_err, o_stable, o_busy, o_rdy);
    total++; if (o_nwr != 0 || o_rc != 1 || o_err !== 1'b1) begin bad++; $display("FAIL oor_write got=wr%0d cyc%0d err%b exp=wr0 cyc1 err1", o_nwr, o_rc, o_err); end
  endtask

  task automatic test_backpressure;
    run_txn(1'b0, 10'd42, '0, 1, 32'hCAFE_0042, 20, 1'b0,
            o_done, o_nrd, o_nwr, o_pc, o_pa, o_pd, o_rc, o_rd, o_err, o_stable, o_busy, o_rdy);
    exp_rd++;
    total++; if (!o_stable) begin bad++; $display("FAIL bp_stable got=0 exp=1"); end
    total++; if (!o_busy) begin bad++; $display("FAIL bp_req_ready_low got=0 exp=1"); end
    total++; if (o_rd !== 32'hCAFE_0042 || o_err !== 1'b0 || !o_done || !o_rdy) begin bad++; $display("FAIL bp_rsp got=%h/%b done=%0d rdy=%0d exp=cafe0042/0 done=1 rdy=1", o_rd, o_err, o_done, o_rdy); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    bus.host_req_valid = 1'b1; bus.host_req_write = 1'b0; bus.host_req_addr = 10'd3;
    @(posedge clk); #1;            // handshake edge
    bus.host_req_valid = 1'b0;
    repeat (2) @(posedge clk);     // now in RD_WAIT
    #1 rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.cpu_rd_result = 32'h7777_7777;
    bus.cpu_rd_result_valid = 1'b1;
    @(posedge clk); #1;
    bus.cpu_rd_result_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (bus.host_rsp_valid !== 1'b0 || bus.host_req_ready !== 1'b1 || bus.cpu_rd_valid !== 1'b0)
        begin bad++; $display("FAIL reset_mid got=rsp%b rdy%b rd%b exp=rsp0 rdy1 rd0", bus.host_rsp_valid, bus.host_req_ready, bus.cpu_rd_valid); end
      total++; if (bus.host_rsp_rdata !== '0 || bus.host_rsp_err !== 1'b0 || bus.cpu_rd_addr !== '0)
        begin bad++; $display("FAIL reset_mid_vals got=%h/%b/%0d exp=0/0/0", bus.host_rsp_rdata, bus.host_rsp_err, bus.cpu_rd_addr); end
    end
  endtask

  task automatic test_random;
    bit wr, wrong, oor;
    int d, hold, e_rc;
    logic [IW-1:0] a;
    logic [RW-1:0] wd, rv, e_rd;
    logic e_err;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? IW'($urandom_range(SIZE, 1023)) : IW'($urandom_range(0, SIZE - 1));
      wd = $urandom; rv = $urandom;
      d  = $urandom_range(0, 13);
      hold = $urandom_range(0, 3);
      wrong = 1'($urandom_range(0, 1));
      // reference: out of range answers at once; a strobe d cycles after the
      // pulse wins if it lands inside the TC-cycle wait window
      oor = (int'(a) >= SIZE);
      if (oor) begin
        e_rc = 1; e_err = 1'b1; e_rd = '0;
      end else if (d >= 1 && d <= TC) begin
        e_rc = d + 2; e_err = 1'b0; e_rd = wr ? '0 : rv;
        if (wr) exp_wr++; else exp_rd++;
      end else begin
        e_rc = TC + 2; e_err = 1'b1; e_rd = '0; exp_to++;
      end
      run_txn(wr, a, wd, d, rv, hold, wrong,
              o_done, o_nrd, o_nwr, o_pc, o_pa, o_pd, o_rc, o_rd, o_err, o_stable, o_busy, o_rdy);
      total++; if (!o_done || !o_rdy) begin bad++; $display("FAIL rnd%0d done got=%0d/%0d exp=1/1", i, o_done, o_rdy); end
      total++; if (o_nrd != ((!oor && !wr) ? 1 : 0) || o_nwr != ((!oor && wr) ? 1 : 0))
        begin bad++; $display("FAIL rnd%0d pulses got=rd%0d wr%0d oor=%0d wr=%0d", i, o_nrd, o_nwr, oor, wr); end
      if (!oor) begin
        total++; if (o_pa !== a || (wr && o_pd !== wd)) begin bad++; $display("FAIL rnd%0d issue got=%0d/%h exp=%0d/%h", i, o_pa, o_pd, a, wd); end
      end
      total++; if (o_rc != e_rc) begin bad++; $display("FAIL rnd%0d latency got=%0d exp=%0d", i, o_rc, e_rc); end
      total++; if (o_rd !== e_rd || o_err !== e_err) begin bad++; $display("FAIL rnd%0d rsp got=%h/%b exp=%h/%b", i, o_rd, o_err, e_rd, e_err); end
      total++; if (!o_stable || !o_busy) begin bad++; $display("FAIL rnd%0d hold got=stable%0d busy%0d exp=1/1", i, o_stable, o_busy); end
    end
  endtask

`ifdef PIFO_CPU_MASTER_STATS_EN
  task automatic test_stats;
    @(negedge clk);
    total++; if (stat_rd_count !== 16'(exp_rd) || stat_wr_count !== 16'(exp_wr) || stat_timeout_count !== 16'(exp_to))
      begin bad++; $display("FAIL stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", stat_rd_count, stat_wr_count, stat_timeout_count, exp_rd, exp_wr, exp_to); end
  endtask
`endif

  initial begin
    bus.host_req_valid = 1'b0; bus.host_req_write = 1'b0;
    bus.host_req_addr = '0; bus.host_req_wdata = '0;
    bus.host_rsp_ready = 1'b0;
    bus.cpu_rd_result_valid = 1'b0; bus.cpu_rd_result = '0;
    bus.cpu_wr_result_valid = 1'b0;
    test_reset;
    test_read;
    test_write;
    test_timeout;
    test_out_of_range;
    test_backpressure;
    test_random;
`ifdef PIFO_CPU_MASTER_STATS_EN
    test_stats;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
